// File: rtl/eth_arb_pkg.sv
// Shared state encoding and synthetic-beat constants for the Ethernet TX frame arbiter.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PASS = 2'd1,
    ARB_DROP = 2'd2
  } arb_state_e;

  // Synthetic terminating beat used to close a frame whose source stalled too long
  localparam int unsigned SYNTH_TDATA = 0;
  localparam int unsigned SYNTH_TKEEP = 1;
  localparam logic        SYNTH_TLAST = 1'b1;
  localparam logic        SYNTH_TUSER = 1'b1;

  // Width of a counter that must reach 'limit'; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/eth_axis_skid_reg.sv
// Two-entry AXI-stream skid register: registered outputs, full throughput, ready cut.
module eth_axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  // Upstream may push whenever the overflow slot is free
  assign s_ready = ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!m_valid || m_ready) begin
      if (skid_valid) begin
        m_data     <= skid_data;
        m_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end
    end else if (s_valid && !skid_valid) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter merging several AXI-stream TX requesters into one MAC stream,
// with a mid-frame stall watchdog that closes a hung frame with a bad-frame beat.
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned S_COUNT       = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter bit          KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned STALL_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [S_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index,
  output logic                          frame_abort
);

  localparam int unsigned IDX_W  = $clog2(S_COUNT);
  localparam int unsigned CNT_W  = cnt_width(STALL_TIMEOUT);
  localparam int unsigned PLD_W  = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam bit          TO_EN  = (STALL_TIMEOUT != 0);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic                   grant_valid_q, abort_q, abort_d;

  logic [DATA_WIDTH-1:0]  src_data [S_COUNT];
  logic [KEEP_WIDTH-1:0]  src_keep [S_COUNT];

  logic [IDX_W-1:0]       arb_sel;
  logic                   arb_hit;
  int unsigned            arb_idx;

  logic                   g_valid, g_last, timeout;
  logic [PLD_W-1:0]       buf_payload, m_payload;
  logic                   buf_valid, buf_ready;

  // Per-port views of the flat requester buses
  for (genvar i = 0; i < S_COUNT; i++) begin : g_src
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_keep[i] = KEEP_ENABLE ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]
                                     : {KEEP_WIDTH{1'b1}};
  end

  assign g_valid = s_axis_tvalid[grant_q];
  assign g_last  = s_axis_tlast[grant_q];
  assign timeout = TO_EN && (stall_q == CNT_W'(STALL_TIMEOUT));

  // Round-robin search: first requester strictly after the last winner, wrapping
  always_comb begin
    arb_sel = rr_q;
    arb_hit = 1'b0;
    arb_idx = 0;
    for (int unsigned k = 1; k <= S_COUNT; k++) begin
      arb_idx = (32'(rr_q) + k) % S_COUNT;
      if (!arb_hit && s_axis_tvalid[IDX_W'(arb_idx)]) begin
        arb_hit = 1'b1;
        arb_sel = IDX_W'(arb_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_q          <= IDX_W'(S_COUNT - 1);
      stall_q       <= '0;
      grant_valid_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      stall_q       <= stall_d;
      grant_valid_q <= (state_d != ARB_IDLE);
      abort_q       <= abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    stall_d       = stall_q;
    abort_d       = 1'b0;
    s_axis_tready = '0;
    buf_valid     = 1'b0;
    buf_payload   = {s_axis_tuser[grant_q], g_last, src_keep[grant_q], src_data[grant_q]};

    unique case (state_q)
      ARB_IDLE: begin
        if (arb_hit) begin
          grant_d = arb_sel;
          rr_d    = arb_sel;
          stall_d = '0;
          state_d = ARB_PASS;
        end
      end

      ARB_PASS: begin
        if (timeout) begin
          // Source hung mid-frame: terminate with a bad-frame beat, hold the real source off
          buf_valid   = 1'b1;
          buf_payload = {SYNTH_TUSER, SYNTH_TLAST, KEEP_WIDTH'(SYNTH_TKEEP), DATA_WIDTH'(SYNTH_TDATA)};
          if (buf_ready) begin
            abort_d = 1'b1;
            stall_d = '0;
            state_d = ARB_DROP;
          end
        end else begin
          s_axis_tready[grant_q] = buf_ready;
          buf_valid              = g_valid;
          if (g_valid && buf_ready) begin
            stall_d = '0;
            if (g_last) state_d = ARB_IDLE;
          end else if (!g_valid && TO_EN) begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
      end

      ARB_DROP: begin
        // Swallow the remainder of the aborted frame
        s_axis_tready[grant_q] = 1'b1;
        if (g_valid && g_last) state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  eth_axis_skid_reg #(
    .WIDTH (PLD_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (buf_payload),
    .s_valid (buf_valid),
    .s_ready (buf_ready),
    .m_data  (m_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = m_payload[DATA_WIDTH-1:0];
  assign m_axis_tkeep = m_payload[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast = m_payload[DATA_WIDTH + KEEP_WIDTH];
  assign m_axis_tuser = m_payload[DATA_WIDTH + KEEP_WIDTH + 1];

  assign grant_valid = grant_valid_q;
  assign grant_index = grant_q;
  assign frame_abort = abort_q;

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 The block SHALL have parameter S_COUNT, default 4: number of TX requester streams, 2..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: AXI-stream data width.
REQ-003 The block SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): tkeep present.
REQ-004 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-005 The block SHALL have parameter STALL_TIMEOUT, default 256: mid-frame source-stall limit in cycles; 0 disables the limit.
REQ-006 clk  in  1  the single clock for all logic.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 s_axis_tdata  in  S_COUNT*DATA_WIDTH  requester data; port i occupies slice i.
REQ-009 s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  requester byte enables.
REQ-010 s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  S_COUNT each  requester valid, end-of-frame, bad-frame flag.
REQ-011 s_axis_tready  out  S_COUNT  per-requester ready.
REQ-012 m_axis_tdata / tkeep / tvalid / tlast / tuser  out  DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1  merged stream to the MAC TX FIFO.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 grant_valid  out  1  a requester currently owns the output.
REQ-015 grant_index  out  $clog2(S_COUNT)  index of the owning requester.
REQ-016 frame_abort  out  1  one-cycle pulse when a frame is terminated by timeout.

Function
REQ-017 The block SHALL use the states IDLE, PASS and DROP.
REQ-018 In IDLE, if any s_axis_tvalid is high, the block SHALL grant the first requesting port found searching upward, with wrap, from rr_ptr+1, and SHALL enter PASS on the next cycle; no beat transfers in the grant cycle.
REQ-019 On grant, rr_ptr SHALL load the granted index; grant_valid and grant_index SHALL become valid together with PASS.
REQ-020 In PASS, s_axis_tready[g] SHALL equal the output-buffer-ready signal, and every other s_axis_tready SHALL be 0.
REQ-021 Granted beats SHALL pass tdata, tkeep, tlast and tuser unmodified.
REQ-022 A transfer with tlast=1 SHALL return the block to IDLE on the next cycle, deasserting grant_valid; the minimum inter-frame gap is 1 cycle.
REQ-023 The stall counter SHALL increment each PASS cycle in which s_axis_tvalid[g]=0, SHALL clear on any granted transfer, and SHALL saturate at STALL_TIMEOUT.
REQ-024 When the stall counter equals STALL_TIMEOUT (non-zero), the block SHALL insert one synthetic beat once the output buffer is ready: tdata=0, tkeep=1, tlast=1, tuser=1.
REQ-025 In the cycle the synthetic beat is accepted, frame_abort SHALL pulse for one cycle, and the block SHALL enter DROP.
REQ-026 In DROP, s_axis_tready[g] SHALL be 1 and beats SHALL be discarded (not forwarded) until a tlast transfer, after which the block SHALL return to IDLE.
REQ-027 Downstream back-pressure (m_axis_tready=0) SHALL NOT advance the stall counter unless s_axis_tvalid[g]=0.
REQ-028 A tvalid on a non-granted port during PASS or DROP SHALL be held off and SHALL NOT affect the current grant.
REQ-029 The output SHALL be a 2-entry skid buffer: latency 1 cycle from source to master, sustained throughput 1 beat/cycle under continuous m_axis_tready, and the buffer SHALL never drop or duplicate a beat.

Reset
REQ-030 On rst, the block SHALL enter IDLE with rr_ptr=S_COUNT-1, so port 0 wins first, stall counter=0, and the skid buffer empty.
REQ-031 During rst, m_axis_tvalid, s_axis_tready, grant_valid, grant_index and frame_abort SHALL all be 0.
REQ-032 A reset mid-frame SHALL discard buffered beats; no tlast is emitted for the truncated frame, because the downstream FIFO shares the reset.

Structure
REQ-033 State encoding and synthetic-beat constants SHALL live in the shared package eth_arb_pkg.
REQ-034 The output skid buffer SHALL be a sub-module, eth_axis_skid_reg; the arbitration and FSM logic SHALL remain inline.

Verification
REQ-035 Ports 0 and 2 each hold a 3-beat frame at reset release -> output shows port 0's frame, then port 2's, each with grant_index matching and a 1-cycle gap.
REQ-036 All 4 ports continuously request 1-beat frames -> grant order 0,1,2,3,0, with no port served twice before the others.
REQ-037 STALL_TIMEOUT=4; port 1 sends 2 beats, then drops tvalid -> after 4 stall cycles, a synthetic beat appears (tdata=0, tlast=1, tuser=1), frame_abort pulses once, and the following 3 late beats plus tlast are absorbed with none on m_axis.
REQ-038 m_axis_tready toggles 1/0 every cycle during a 16-beat frame -> all 16 beats arrive in order, with no loss or duplicate and no abort.
REQ-039 rst asserted at beat 5 of a 10-beat frame -> all outputs go to 0 immediately; after release, port 0 wins first arbitration.
